match_collector: RTL and testbench
==================================

Name: match_collector

Overview:
- Sits directly downstream of the Tanimoto comparator and consumes its per-pair match bit and valid strobe.
- Tracks which query/reference pair each valid result belongs to, using a reference index and a query index.
- Writes the {query, reference} ID pair of every match into a small first-word-fall-through FIFO.
- Presents FIFO contents on a valid/ready stream for the host-side writer, with overflow and match statistics.

Parameters:
- ID_WIDTH, 16: width of the query and reference indices.
- FIFO_DEPTH, 16: number of match-pair entries; power of two, at least 2.
- LVL_WIDTH, $clog2(FIFO_DEPTH)+1: width of the fill-level output.
- STAT_WIDTH, 32: width of the match and drop counters.

Ports:
- clk  in  1  single system clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_Clear  in  1  synchronous clear of indices, FIFO and statistics.
- i_RefCount  in  ID_WIDTH  number of reference vectors per query; 0 means 2^ID_WIDTH.
- i_Valid  in  1  comparator result valid.
- i_Match  in  1  comparator result bit (1 = dissimilarity under threshold).
- o_Valid  out  1  head FIFO entry available.
- i_Ready  in  1  consumer accepts head entry.
- o_Data  out  2*ID_WIDTH  {query_idx, ref_idx} of the head entry.
- o_Level  out  LVL_WIDTH  current FIFO occupancy.
- o_Overflow  out  1  sticky flag: at least one match was dropped.
- o_MatchCnt  out  STAT_WIDTH  matches seen, including dropped ones; saturating.
- o_DropCnt  out  STAT_WIDTH  matches dropped; saturating.
- o_QueryIdx  out  ID_WIDTH  current query index, for progress monitoring.

Behaviour:
- Reset (rstn low, asynchronous):
  - Indices, FIFO pointers, o_Level, o_MatchCnt, o_DropCnt and o_Overflow go to 0.
  - o_Valid goes to 0; o_Data goes to 0.
  - Reset mid-stream discards all queued entries, with no partial output.
- i_Clear (synchronous):
  - Has the same effect as reset, one cycle after it is sampled.
  - Has priority over a push or pop in the same cycle; that input is ignored.
- Index tracking, on each cycle with i_Valid=1:
  - The pair ID is the current {query_idx, ref_idx}, captured before any increment.
  - If ref_idx == i_RefCount-1 (mod 2^ID_WIDTH), ref_idx wraps to 0 and query_idx increments.
  - Otherwise ref_idx increments.
  - query_idx wraps naturally at 2^ID_WIDTH.
  - i_Match is ignored when i_Valid=0.
  - i_RefCount must be stable between clears; behaviour on change mid-query is undefined.
- Push (push_req = i_Valid & i_Match):
  - o_MatchCnt increments, saturating at all-ones.
  - The entry is accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise it is dropped: o_DropCnt increments (saturating) and o_Overflow is set.
  - o_Overflow stays set until reset or i_Clear.
- Pop (pop = o_Valid & i_Ready):
  - Advances the read pointer.
  - i_Ready while o_Valid=0 has no effect.
- Output:
  - FWFT: o_Data is driven from the head entry and o_Valid = (o_Level != 0).
  - Latency: a match in cycle N into an empty FIFO gives o_Valid=1 with that pair in cycle N+1.
  - o_Data is held stable while o_Valid=1 and i_Ready=0.
- Level:
  - o_Level increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop.
  - Range is 0..FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full = (o_Level == FIFO_DEPTH).
- No combinational path from i_Valid/i_Match to o_Valid/o_Data. A path from i_Ready to internal state is permitted.

Test Plan:
- Index walk: i_RefCount=3, 7 valids all matching, i_Ready=1.
  - Required output: (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0) in order, one cycle after each input.
  - o_QueryIdx ends at 2.
- Sparse matches: i_RefCount=4, 8 valids with i_Match=1 only on the 2nd and 7th.
  - Required output: exactly (0,1) and (1,2).
  - o_MatchCnt=2, o_DropCnt=0.
- Overflow: FIFO_DEPTH=16, i_Ready=0, 20 consecutive matches.
  - o_Level=16, o_DropCnt=4, o_Overflow=1.
  - After draining, entries 0..15 come out in order, and o_Overflow stays 1.
- Full with simultaneous push+pop: fill to 16, then assert i_Ready with one matching valid.
  - The new entry is accepted, o_Level stays 16 and o_DropCnt is unchanged.
- Backpressure hold: 3 entries queued; toggle i_Ready 1,0,0,1,1.
  - o_Data is stable during the low cycles.
  - Exactly 3 pops occur and o_Valid falls after the last one.
- Reset/clear mid-operation, with 5 entries queued, indices at (2,1) and o_Overflow=1:
  - i_Clear pulse: everything reads 0 in the next cycle, and the next match reports (0,0).
  - Repeating the same setup with an asynchronous rstn pulse between clock edges zeroes the outputs immediately.

Source files
------------

// File: rtl/match_collector.sv
// match_collector: tags comparator results with {query, ref} indices and
// queues the matching pairs in a FWFT FIFO with a valid/ready output.
//
// Ports:
//   clk, rstn        clock, async active-low reset
//   i_Clear          sync clear of indices, FIFO and statistics
//   i_RefCount       reference vectors per query (0 = 2^ID_WIDTH)
//   i_Valid/i_Match  comparator result strobe and match bit
//   o_Valid/i_Ready  output stream handshake
//   o_Data           {query_idx, ref_idx} of head entry
//   o_Level          FIFO occupancy
//   o_Overflow       sticky: a match was dropped
//   o_MatchCnt       matches seen (saturating)
//   o_DropCnt        matches dropped (saturating)
//   o_QueryIdx       current query index
module match_collector #(
    parameter int ID_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int STAT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_Clear,
    input  logic [ID_WIDTH-1:0]     i_RefCount,
    input  logic                    i_Valid,
    input  logic                    i_Match,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [2*ID_WIDTH-1:0]   o_Data,
    output logic [LVL_WIDTH-1:0]    o_Level,
    output logic                    o_Overflow,
    output logic [STAT_WIDTH-1:0]   o_MatchCnt,
    output logic [STAT_WIDTH-1:0]   o_DropCnt,
    output logic [ID_WIDTH-1:0]     o_QueryIdx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]   r_RefIdx;
    logic [ID_WIDTH-1:0]   r_QueryIdx;
    logic [2*ID_WIDTH-1:0] r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_WrPtr;
    logic [PTR_W-1:0]      r_RdPtr;
    logic [LVL_WIDTH-1:0]  r_Level;
    logic                  r_Overflow;
    logic [STAT_WIDTH-1:0] r_MatchCnt;
    logic [STAT_WIDTH-1:0] r_DropCnt;

    logic [ID_WIDTH-1:0]   w_RefLastIdx;
    logic                  w_RefLast;
    logic                  w_PushReq;
    logic                  w_Full;
    logic                  w_NotEmpty;
    logic                  w_Pop;
    logic                  w_PushAcc;
    logic                  w_Drop;

    // RefCount of 0 wraps to all-ones, giving a 2^ID_WIDTH ref loop.
    assign w_RefLastIdx = i_RefCount - ID_WIDTH'(1);
    assign w_RefLast    = (r_RefIdx == w_RefLastIdx);

    assign w_PushReq  = i_Valid & i_Match;
    assign w_Full     = (r_Level == LVL_FULL);
    assign w_NotEmpty = (r_Level != '0);
    assign w_Pop      = w_NotEmpty & i_Ready;
    // A full FIFO still takes a new entry when the head leaves this cycle.
    assign w_PushAcc  = w_PushReq & (~w_Full | w_Pop);
    assign w_Drop     = w_PushReq & w_Full & ~w_Pop;

    // Index tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_RefIdx   <= '0;
            r_QueryIdx <= '0;
        end else if (i_Clear) begin
            r_RefIdx   <= '0;
            r_QueryIdx <= '0;
        end else if (i_Valid) begin
            if (w_RefLast) begin
                r_RefIdx   <= '0;
                r_QueryIdx <= r_QueryIdx + ID_WIDTH'(1);
            end else begin
                r_RefIdx   <= r_RefIdx + ID_WIDTH'(1);
            end
        end
    end

    // Storage is not reset; the output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_PushAcc && !i_Clear) begin
            r_Mem[r_WrPtr] <= {r_QueryIdx, r_RefIdx};
        end
    end

    // FIFO pointers and level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Level <= '0;
        end else if (i_Clear) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Level <= '0;
        end else begin
            if (w_PushAcc) begin
                r_WrPtr <= r_WrPtr + PTR_W'(1);
            end
            if (w_Pop) begin
                r_RdPtr <= r_RdPtr + PTR_W'(1);
            end
            case ({w_PushAcc, w_Pop})
                2'b10:   r_Level <= r_Level + LVL_WIDTH'(1);
                2'b01:   r_Level <= r_Level - LVL_WIDTH'(1);
                default: r_Level <= r_Level;
            endcase
        end
    end

    // Statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_MatchCnt <= '0;
            r_DropCnt  <= '0;
            r_Overflow <= 1'b0;
        end else if (i_Clear) begin
            r_MatchCnt <= '0;
            r_DropCnt  <= '0;
            r_Overflow <= 1'b0;
        end else begin
            if (w_PushReq && (r_MatchCnt != '1)) begin
                r_MatchCnt <= r_MatchCnt + STAT_WIDTH'(1);
            end
            if (w_Drop) begin
                r_Overflow <= 1'b1;
                if (r_DropCnt != '1) begin
                    r_DropCnt <= r_DropCnt + STAT_WIDTH'(1);
                end
            end
        end
    end

    assign o_Valid    = w_NotEmpty;
    assign o_Data     = w_NotEmpty ? r_Mem[r_RdPtr] : '0;
    assign o_Level    = r_Level;
    assign o_Overflow = r_Overflow;
    assign o_MatchCnt = r_MatchCnt;
    assign o_DropCnt  = r_DropCnt;
    assign o_QueryIdx = r_QueryIdx;

endmodule

// File: tb/tb_match_collector.sv
// tb_match_collector: directed-vector bench for match_collector.
// Drives inputs 1ns after the rising edge and samples there too.
module tb_match_collector;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_Clear;
    logic [15:0] i_RefCount;
    logic        i_Valid;
    logic        i_Match;
    logic        o_Valid;
    logic        i_Ready;
    logic [31:0] o_Data;
    logic [4:0]  o_Level;
    logic        o_Overflow;
    logic [31:0] o_MatchCnt;
    logic [31:0] o_DropCnt;
    logic [15:0] o_QueryIdx;

    int n_pass = 0;
    int n_total = 0;

    match_collector dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_Clear    (i_Clear),
        .i_RefCount (i_RefCount),
        .i_Valid    (i_Valid),
        .i_Match    (i_Match),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Data     (o_Data),
        .o_Level    (o_Level),
        .o_Overflow (o_Overflow),
        .o_MatchCnt (o_MatchCnt),
        .o_DropCnt  (o_DropCnt),
        .o_QueryIdx (o_QueryIdx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        i_Valid = 1'b0;
        i_Match = 1'b0;
        i_Ready = 1'b0;
        i_Clear = 1'b1;
        tick();
        i_Clear = 1'b0;
    endtask

    task automatic push_n(input int n);
        i_Valid = 1'b1;
        i_Match = 1'b1;
        for (int i = 0; i < n; i++) tick();
        i_Valid = 1'b0;
        i_Match = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_Valid), 64'd0);
        chk({tag, "_data"}, 64'(o_Data), 64'd0);
        chk({tag, "_level"}, 64'(o_Level), 64'd0);
        chk({tag, "_ovf"}, 64'(o_Overflow), 64'd0);
        chk({tag, "_mcnt"}, 64'(o_MatchCnt), 64'd0);
        chk({tag, "_dcnt"}, 64'(o_DropCnt), 64'd0);
        chk({tag, "_qidx"}, 64'(o_QueryIdx), 64'd0);
    endtask

    // 5 entries queued, indices (2,1), overflow set.
    // RefCount=8: 17 valids -> q=2, r=1; 16 kept, 1 dropped; pop 11.
    task automatic mid_setup();
        do_clear();
        i_RefCount = 16'd8;
        push_n(17);
        i_Ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        i_Ready = 1'b0;
        chk("mid_level", 64'(o_Level), 64'd5);
        chk("mid_qidx", 64'(o_QueryIdx), 64'd2);
        chk("mid_ovf", 64'(o_Overflow), 64'd1);
    endtask

    logic [31:0] walk_exp [7];
    logic [31:0] got_q [$];
    logic [31:0] held;
    int          pops;
    logic [4:0]  rdy_pat;

    initial begin
        rstn       = 1'b0;
        i_Clear    = 1'b0;
        i_RefCount = 16'd3;
        i_Valid    = 1'b0;
        i_Match    = 1'b0;
        i_Ready    = 1'b0;
        tick();
        tick();
        chk_zero("rst");
        rstn = 1'b1;
        tick();

        // Index walk, RefCount=3
        walk_exp[0] = {16'd0, 16'd0};
        walk_exp[1] = {16'd0, 16'd1};
        walk_exp[2] = {16'd0, 16'd2};
        walk_exp[3] = {16'd1, 16'd0};
        walk_exp[4] = {16'd1, 16'd1};
        walk_exp[5] = {16'd1, 16'd2};
        walk_exp[6] = {16'd2, 16'd0};
        i_RefCount = 16'd3;
        i_Ready = 1'b1;
        i_Valid = 1'b1;
        i_Match = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("walk_v%0d", i), 64'(o_Valid), 64'd1);
            chk($sformatf("walk_d%0d", i), 64'(o_Data), 64'(walk_exp[i]));
        end
        i_Valid = 1'b0;
        i_Match = 1'b0;
        tick();
        chk("walk_empty", 64'(o_Valid), 64'd0);
        chk("walk_qidx", 64'(o_QueryIdx), 64'd2);

        // Sparse matches, RefCount=4, match on 2nd and 7th
        do_clear();
        i_RefCount = 16'd4;
        i_Ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            i_Valid = 1'b1;
            i_Match = (i == 1 || i == 6);
            tick();
            if (o_Valid) got_q.push_back(o_Data);
        end
        i_Valid = 1'b0;
        i_Match = 1'b0;
        tick();
        if (o_Valid) got_q.push_back(o_Data);
        chk("sparse_n", 64'(got_q.size()), 64'd2);
        chk("sparse_0", (got_q.size() > 0) ? 64'(got_q[0]) : '1,
            64'({16'd0, 16'd1}));
        chk("sparse_1", (got_q.size() > 1) ? 64'(got_q[1]) : '1,
            64'({16'd1, 16'd2}));
        chk("sparse_mcnt", 64'(o_MatchCnt), 64'd2);
        chk("sparse_dcnt", 64'(o_DropCnt), 64'd0);

        // Overflow: 20 matches into a stalled FIFO
        do_clear();
        i_RefCount = 16'd0;
        push_n(20);
        chk("ovf_level", 64'(o_Level), 64'd16);
        chk("ovf_dcnt", 64'(o_DropCnt), 64'd4);
        chk("ovf_mcnt", 64'(o_MatchCnt), 64'd20);
        chk("ovf_flag", 64'(o_Overflow), 64'd1);
        i_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), 64'(o_Data),
                64'({16'd0, 16'(i)}));
            tick();
        end
        chk("ovf_empty", 64'(o_Valid), 64'd0);
        chk("ovf_sticky", 64'(o_Overflow), 64'd1);

        // Full with simultaneous push and pop
        do_clear();
        i_RefCount = 16'd0;
        push_n(16);
        chk("fpp_full", 64'(o_Level), 64'd16);
        i_Ready = 1'b1;
        i_Valid = 1'b1;
        i_Match = 1'b1;
        tick();
        i_Valid = 1'b0;
        i_Match = 1'b0;
        chk("fpp_level", 64'(o_Level), 64'd16);
        chk("fpp_dcnt", 64'(o_DropCnt), 64'd0);
        chk("fpp_ovf", 64'(o_Overflow), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("fpp_drain%0d", i), 64'(o_Data),
                64'({16'd0, 16'(i)}));
            tick();
        end
        chk("fpp_empty", 64'(o_Level), 64'd0);

        // Backpressure hold: ready pattern 1,0,0,1,1
        do_clear();
        i_RefCount = 16'd0;
        push_n(3);
        rdy_pat = 5'b11001;
        pops = 0;
        for (int k = 0; k < 5; k++) begin
            i_Ready = rdy_pat[k];
            held = o_Data;
            if (o_Valid && i_Ready) pops++;
            tick();
            if (!rdy_pat[k]) begin
                chk($sformatf("bp_hold%0d", k), 64'(o_Data), 64'(held));
                chk($sformatf("bp_val%0d", k), 64'(o_Data),
                    64'({16'd0, 16'd1}));
            end
        end
        i_Ready = 1'b0;
        chk("bp_pops", 64'(pops), 64'd3);
        chk("bp_empty", 64'(o_Valid), 64'd0);

        // Synchronous clear mid-operation
        mid_setup();
        i_Clear = 1'b1;
        i_Valid = 1'b1;
        i_Match = 1'b1;
        i_Ready = 1'b1;
        tick();
        i_Clear = 1'b0;
        i_Valid = 1'b0;
        i_Match = 1'b0;
        i_Ready = 1'b0;
        chk_zero("clr");
        i_Valid = 1'b1;
        i_Match = 1'b1;
        tick();
        i_Valid = 1'b0;
        i_Match = 1'b0;
        chk("clr_next_v", 64'(o_Valid), 64'd1);
        chk("clr_next_d", 64'(o_Data), 64'({16'd0, 16'd0}));

        // Asynchronous reset between edges
        mid_setup();
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("arst");
        rstn = 1'b1;
        tick();
        chk("arst_hold", 64'(o_Level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
